id_ex_stage: RTL and testbench

//  ID/EX pipeline stage for the MIPS core. Registers the decoder control bundle and decoded operands

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/load_use_detector.sv | 27 ++
 rtl/id_ex_stage.sv | 98 +++++++++
 tb/tb_id_ex_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: opcodes, control bundle layout
// and operand-usage helpers used by the hazard logic.
package mips_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam int CTRL_W         = 12;
    localparam int CTRL_JUMP      = 11;
    localparam int CTRL_REGDST    = 10;
    localparam int CTRL_ALUSRC    = 9;
    localparam int CTRL_MEMTOREG  = 8;
    localparam int CTRL_REGWRITE  = 7;
    localparam int CTRL_MEMREAD   = 6;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_BRANCHNE  = 4;
    localparam int CTRL_BRANCHEQ  = 3;
    localparam int CTRL_ALUOP_MSB = 2;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 12'b0;

    // Jumps and LUI never read rs; everything else does.
    function automatic logic uses_rs(input logic [5:0] op);
        logic r;
        r = 1'b1;
        case (op)
            OP_J, OP_JAL, OP_LUI: r = 1'b0;
            default:              r = 1'b1;
        endcase
        return r;
    endfunction

    // Only R-type, branches and stores read rt as a source.
    function automatic logic uses_rt(input logic [5:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_R_TYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check between the load in EX
// and the source operands of the instruction in ID.
module load_use_detector
    import mips_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [5:0]                op,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      ex_memread,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic                      hazard
);

    logic rs_match;
    logic rt_match;
    logic ex_rt_live;

    // $zero is never written, so a load targeting it cannot cause a hazard.
    assign ex_rt_live = (ex_rt != '0);
    assign rs_match   = uses_rs(op) && (ex_rt == id_rs);
    assign rt_match   = uses_rt(op) && (ex_rt == id_rt);

    assign hazard = ex_memread & ex_rt_live & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// redirect squash, global hold and a saturating bubble counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic [5:0]                id_op_i,
    input  logic [CTRL_W-1:0]         id_ctrl_i,
    input  logic [DATA_WIDTH-1:0]     id_pc4_i,
    input  logic [DATA_WIDTH-1:0]     id_rd1_i,
    input  logic [DATA_WIDTH-1:0]     id_rd2_i,
    input  logic [DATA_WIDTH-1:0]     id_imm_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
    output logic [CTRL_W-1:0]         ex_ctrl_o,
    output logic [DATA_WIDTH-1:0]     ex_pc4_o,
    output logic [DATA_WIDTH-1:0]     ex_rd1_o,
    output logic [DATA_WIDTH-1:0]     ex_rd2_o,
    output logic [DATA_WIDTH-1:0]     ex_imm_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_o,
    output logic                      stall_o,
    output logic [CNT_WIDTH-1:0]      bubble_cnt_o
);

    logic hazard;
    logic load_data;
    logic kill_ctrl;
    logic bubble;
    logic cnt_full;

    load_use_detector #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_load_use_detector (
        .op        (id_op_i),
        .id_rs     (id_rs_i),
        .id_rt     (id_rt_i),
        .ex_memread(ex_ctrl_o[CTRL_MEMREAD]),
        .ex_rt     (ex_rt_o),
        .hazard    (hazard)
    );

    assign stall_o = hazard & ~flush_i;

    // Redirect outranks hold so a taken branch is never lost to a memory wait.
    assign load_data = flush_i | ~hold_i;
    assign bubble    = ~flush_i & ~hold_i & hazard;
    assign kill_ctrl = flush_i | bubble;
    assign cnt_full  = &bubble_cnt_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ctrl_o <= CTRL_NOP;
        end else if (kill_ctrl) begin
            ex_ctrl_o <= CTRL_NOP;
        end else if (!hold_i) begin
            ex_ctrl_o <= id_ctrl_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_pc4_o <= '0;
            ex_rd1_o <= '0;
            ex_rd2_o <= '0;
            ex_imm_o <= '0;
            ex_rs_o  <= '0;
            ex_rt_o  <= '0;
            ex_rd_o  <= '0;
        end else if (load_data) begin
            ex_pc4_o <= id_pc4_i;
            ex_rd1_o <= id_rd1_i;
            ex_rd2_o <= id_rd2_i;
            ex_imm_o <= id_imm_i;
            ex_rs_o  <= id_rs_i;
            ex_rt_o  <= id_rt_i;
            ex_rd_o  <= id_rd_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_o <= '0;
        end else if (bubble && !cnt_full) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// A 4-bit-counter copy shares the stimulus to reach saturation quickly.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        hold_i;
    logic        flush_i;
    logic [5:0]  id_op_i;
    logic [11:0] id_ctrl_i;
    logic [31:0] id_pc4_i, id_rd1_i, id_rd2_i, id_imm_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;

    logic [11:0] ex_ctrl_o;
    logic [31:0] ex_pc4_o, ex_rd1_o, ex_rd2_o, ex_imm_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
    logic        stall_o;
    logic [15:0] bubble_cnt_o;

    logic [11:0] s_ctrl;
    logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic        s_stall;
    logic [3:0]  s_cnt;

    int n_cmp;
    int n_bad;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .hold_i(hold_i), .flush_i(flush_i),
        .id_op_i(id_op_i), .id_ctrl_i(id_ctrl_i), .id_pc4_i(id_pc4_i),
        .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .ex_ctrl_o(ex_ctrl_o), .ex_pc4_o(ex_pc4_o), .ex_rd1_o(ex_rd1_o),
        .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o),
        .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .stall_o(stall_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_stage #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .hold_i(hold_i), .flush_i(flush_i),
        .id_op_i(id_op_i), .id_ctrl_i(id_ctrl_i), .id_pc4_i(id_pc4_i),
        .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .ex_ctrl_o(s_ctrl), .ex_pc4_o(s_pc4), .ex_rd1_o(s_rd1),
        .ex_rd2_o(s_rd2), .ex_imm_o(s_imm), .ex_rs_o(s_rs),
        .ex_rt_o(s_rt), .ex_rd_o(s_rd), .stall_o(s_stall),
        .bubble_cnt_o(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [11:0] ctrl,
                         input logic [31:0] pc4, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        id_op_i = op; id_ctrl_i = ctrl; id_pc4_i = pc4;
        id_rd1_i = rd1; id_rd2_i = rd2; id_imm_i = imm;
        id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    endtask

    task automatic test_reset();
        reset = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
        drive(OP_LW, 12'h0E2, 32'h44, 32'h55, 32'h66, 32'h77, 5'd3, 5'd4, 5'd5);
        #3;
        n_cmp++; if (ex_ctrl_o !== 12'h0) begin n_bad++; $display("FAIL reset_ctrl got %h want 000", ex_ctrl_o); end
        n_cmp++; if (ex_pc4_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc4 got %h want 0", ex_pc4_o); end
        n_cmp++; if (ex_rd1_o !== 32'h0) begin n_bad++; $display("FAIL reset_rd1 got %h want 0", ex_rd1_o); end
        n_cmp++; if (ex_rd2_o !== 32'h0) begin n_bad++; $display("FAIL reset_rd2 got %h want 0", ex_rd2_o); end
        n_cmp++; if (ex_imm_o !== 32'h0) begin n_bad++; $display("FAIL reset_imm got %h want 0", ex_imm_o); end
        n_cmp++; if ({ex_rs_o, ex_rt_o, ex_rd_o} !== 15'h0) begin n_bad++; $display("FAIL reset_idx got %h want 0", {ex_rs_o, ex_rt_o, ex_rd_o}); end
        n_cmp++; if (bubble_cnt_o !== 16'h0) begin n_bad++; $display("FAIL reset_cnt got %h want 0", bubble_cnt_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall_o); end
        reset = 1'b1;
    endtask

    task automatic test_passthrough();
        drive(OP_ADDI, 12'h0A6, 32'h104, 32'd5, 32'h11, 32'd7, 5'd1, 5'd2, 5'd0);
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL pass_stall got %b want 0", stall_o); end
        step();
        n_cmp++; if (ex_ctrl_o !== 12'h0A6) begin n_bad++; $display("FAIL pass_ctrl got %h want 0a6", ex_ctrl_o); end
        n_cmp++; if (ex_rd1_o !== 32'd5) begin n_bad++; $display("FAIL pass_rd1 got %h want 5", ex_rd1_o); end
        n_cmp++; if (ex_imm_o !== 32'd7) begin n_bad++; $display("FAIL pass_imm got %h want 7", ex_imm_o); end
        n_cmp++; if (ex_pc4_o !== 32'h104) begin n_bad++; $display("FAIL pass_pc4 got %h want 104", ex_pc4_o); end
        n_cmp++; if (ex_rd2_o !== 32'h11) begin n_bad++; $display("FAIL pass_rd2 got %h want 11", ex_rd2_o); end
        n_cmp++; if (ex_rt_o !== 5'd2) begin n_bad++; $display("FAIL pass_rt got %h want 2", ex_rt_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL pass_stall2 got %b want 0", stall_o); end
    endtask

    task automatic test_load_use();
        drive(OP_LW, 12'h0E2, 32'h108, 32'h20, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0);
        step();
        drive(OP_R_TYPE, 12'h482, 32'h10C, 32'h30, 32'h31, 32'h0, 5'd8, 5'd3, 5'd4);
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %b want 1", stall_o); end
        step();
        n_cmp++; if (ex_ctrl_o !== 12'h0) begin n_bad++; $display("FAIL lu_bubble_ctrl got %h want 000", ex_ctrl_o); end
        n_cmp++; if (bubble_cnt_o !== 16'd1) begin n_bad++; $display("FAIL lu_cnt got %0d want 1", bubble_cnt_o); end
        n_cmp++; if (ex_rs_o !== 5'd8) begin n_bad++; $display("FAIL lu_data_rs got %0d want 8", ex_rs_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL lu_stall_drop got %b want 0", stall_o); end
        step();
        n_cmp++; if (ex_ctrl_o !== 12'h482) begin n_bad++; $display("FAIL lu_enter_ctrl got %h want 482", ex_ctrl_o); end
        n_cmp++; if (ex_rd_o !== 5'd4) begin n_bad++; $display("FAIL lu_enter_rd got %0d want 4", ex_rd_o); end
        n_cmp++; if (bubble_cnt_o !== 16'd1) begin n_bad++; $display("FAIL lu_cnt_hold got %0d want 1", bubble_cnt_o); end
    endtask

    task automatic test_zero_unused();
        drive(OP_LW, 12'h0E2, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0);
        step();
        drive(OP_R_TYPE, 12'h482, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2);
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL zero_rt got %b want 0", stall_o); end
        drive(OP_LW, 12'h0E2, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd9, 5'd0);
        step();
        drive(OP_ADDI, 12'h0A6, 32'h0, 32'h0, 32'h0, 32'h0, 5'd2, 5'd9, 5'd0);
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL addi_rt got %b want 0", stall_o); end
        id_op_i = OP_SW;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL sw_rt got %b want 1", stall_o); end
        id_op_i = OP_J; id_rs_i = 5'd9; id_rt_i = 5'd0;
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL j_rs got %b want 0", stall_o); end
        id_op_i = OP_ADDI;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL addi_rs got %b want 1", stall_o); end
    endtask

    task automatic test_flush_priority();
        flush_i = 1'b1; hold_i = 1'b1;
        id_pc4_i = 32'h300;
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", stall_o); end
        step();
        n_cmp++; if (ex_ctrl_o !== 12'h0) begin n_bad++; $display("FAIL flush_ctrl got %h want 000", ex_ctrl_o); end
        n_cmp++; if (bubble_cnt_o !== 16'd1) begin n_bad++; $display("FAIL flush_cnt got %0d want 1", bubble_cnt_o); end
        n_cmp++; if (ex_pc4_o !== 32'h300) begin n_bad++; $display("FAIL flush_pc4 got %h want 300", ex_pc4_o); end
        flush_i = 1'b0; hold_i = 1'b0;
    endtask

    task automatic test_hold();
        drive(OP_ADDI, 12'h0A6, 32'h200, 32'h55, 32'h66, 32'h77, 5'd1, 5'd2, 5'd0);
        step();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(OP_ORI, 12'h2A1 + 12'(i), 32'h900, 32'hAA, 32'hBB, 32'hCC, 5'd6, 5'd7, 5'd8);
            step();
            n_cmp++; if (ex_ctrl_o !== 12'h0A6) begin n_bad++; $display("FAIL hold_ctrl[%0d] got %h want 0a6", i, ex_ctrl_o); end
            n_cmp++; if (ex_rd1_o !== 32'h55) begin n_bad++; $display("FAIL hold_rd1[%0d] got %h want 55", i, ex_rd1_o); end
        end
        hold_i = 1'b0;
        drive(OP_LW, 12'h0E2, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
        step();
        hold_i = 1'b1;
        drive(OP_R_TYPE, 12'h482, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd3, 5'd4);
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL hold_stall got %b want 1", stall_o); end
        step();
        n_cmp++; if (ex_ctrl_o !== 12'h0E2) begin n_bad++; $display("FAIL hold_haz_ctrl got %h want 0e2", ex_ctrl_o); end
        n_cmp++; if (bubble_cnt_o !== 16'd1) begin n_bad++; $display("FAIL hold_haz_cnt got %0d want 1", bubble_cnt_o); end
        hold_i = 1'b0;
        step();
        n_cmp++; if (bubble_cnt_o !== 16'd2) begin n_bad++; $display("FAIL hold_rel_cnt got %0d want 2", bubble_cnt_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 18; i++) begin
            drive(OP_LW, 12'h0E2, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0);
            step();
            drive(OP_BEQ, 12'h009, 32'h0, 32'h0, 32'h0, 32'h0, 5'd2, 5'd5, 5'd0);
            step();
            if (i == 13) begin
                n_cmp++; if (s_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_reach got %h want f", s_cnt); end
            end
        end
        n_cmp++; if (s_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_stick got %h want f", s_cnt); end
        n_cmp++; if (bubble_cnt_o !== 16'd20) begin n_bad++; $display("FAIL b2b_cnt got %0d want 20", bubble_cnt_o); end
    endtask

    task automatic test_reset_mid_stall();
        drive(OP_LW, 12'h0E2, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
        step();
        drive(OP_R_TYPE, 12'h482, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd3, 5'd4);
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL mid_pre got %b want 1", stall_o); end
        reset = 1'b0;
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL mid_stall got %b want 0", stall_o); end
        n_cmp++; if (ex_ctrl_o !== 12'h0) begin n_bad++; $display("FAIL mid_ctrl got %h want 000", ex_ctrl_o); end
        n_cmp++; if (bubble_cnt_o !== 16'd0) begin n_bad++; $display("FAIL mid_cnt got %0d want 0", bubble_cnt_o); end
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_passthrough();
        test_load_use();
        test_zero_unused();
        test_flush_priority();
        test_hold();
        test_back_to_back();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
